// File: rtl/reg_wb_unit_pkg.sv
// Shared definitions for the register write-back unit and the issue stage.
// Bank encoding and the {gf,num} flat register index used by busy/wr_en/regs.
package reg_wb_unit_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_NUM   = 32;

    localparam logic BANK_GENERAL = 1'b0;
    localparam logic BANK_FLOAT   = 1'b1;

    // Equals {gf,num} because the bank size is a power of two.
    function automatic int unsigned flat_idx(input logic gf, input int unsigned num,
                                             input int unsigned num_regs);
        return gf ? (num_regs + num) : num;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the pointer.
// Latency 0 request->grant; pointer moves past the winner on the granting edge.
module rr_arbiter #(
    parameter  int N  = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] ptr
);

    logic [PW-1:0] ptr_nxt;
    logic          hit;
    int            idx;

    always_comb begin
        gnt     = '0;
        ptr_nxt = ptr;
        hit     = 1'b0;
        idx     = 0;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                idx = int'(ptr) + k;
                if (idx >= N) idx = idx - N;
                if (!hit && req[idx]) begin
                    hit      = 1'b1;
                    gnt[idx] = 1'b1;
                    ptr_nxt  = (idx == N - 1) ? '0 : PW'(idx + 1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr <= '0;
        else     ptr <= ptr_nxt;
    end

endmodule

// File: rtl/reg_wb_unit.sv
// General/float register banks with round-robin write-back arbitration and busy scoreboard.
// Grant is combinational; committed data and wr_en appear one cycle after the grant edge.
module reg_wb_unit
    import reg_wb_unit_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int NUM   = DEF_NUM,
    parameter  int NSRC  = 3,
    localparam int RW    = $clog2(NUM)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NSRC-1:0]         src_valid,
    output logic [NSRC-1:0]         src_ready,
    input  logic [NSRC-1:0]         src_gf,
    input  logic [RW*NSRC-1:0]      src_num,
    input  logic [WIDTH*NSRC-1:0]   src_data,
    input  logic                    rsv_valid,
    input  logic                    rsv_gf,
    input  logic [RW-1:0]           rsv_num,
    output logic [WIDTH*2*NUM-1:0]  regs,
    output logic [2*NUM-1:0]        busy,
    output logic [2*NUM-1:0]        wr_en
);

    localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic [WIDTH-1:0] rf [2*NUM];
    logic [NSRC-1:0]  gnt;
    logic [PW-1:0]    unused_rr_ptr;

    logic             c_vld;
    logic             c_gf;
    logic [RW-1:0]    c_num;
    logic [WIDTH-1:0] c_data;
    logic             c_zero;
    logic             r_zero;
    int unsigned      c_idx;
    int unsigned      r_idx;

    rr_arbiter #(.N(NSRC)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (src_valid),
        .gnt (gnt),
        .ptr (unused_rr_ptr)
    );

    assign src_ready = gnt;

    always_comb begin
        c_vld  = |gnt;
        c_gf   = 1'b0;
        c_num  = '0;
        c_data = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (gnt[i]) begin
                c_gf   = src_gf[i];
                c_num  = src_num[i*RW +: RW];
                c_data = src_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // General r0 is hardwired zero: writes and reservations to it are no-ops.
    assign c_zero = (c_gf == BANK_GENERAL) && (c_num == '0);
    assign r_zero = (rsv_gf == BANK_GENERAL) && (rsv_num == '0);
    assign c_idx  = flat_idx(c_gf, 32'(c_num), NUM);
    assign r_idx  = flat_idx(rsv_gf, 32'(rsv_num), NUM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2*NUM; k++) rf[k] <= '0;
            busy  <= '0;
            wr_en <= '0;
        end else begin
            wr_en <= '0;
            if (c_vld && !c_zero) begin
                rf[c_idx]    <= c_data;
                busy[c_idx]  <= 1'b0;
                wr_en[c_idx] <= 1'b1;
            end
            // Reservation is newer than the retiring write, so it lands last and wins.
            if (rsv_valid && !r_zero) busy[r_idx] <= 1'b1;
        end
    end

    for (genvar k = 0; k < 2*NUM; k++) begin : g_flat
        assign regs[k*WIDTH +: WIDTH] = rf[k];
    end

endmodule

// File: tb/tb_reg_wb_unit.sv
// Directed test of reg_wb_unit: arbitration order, r0 hardwiring, scoreboard, reset.
module tb_reg_wb_unit;

    localparam int WIDTH = 32;
    localparam int NUM   = 32;
    localparam int NSRC  = 3;
    localparam int RW    = $clog2(NUM);

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NSRC-1:0]        src_valid;
    logic [NSRC-1:0]        src_ready;
    logic [NSRC-1:0]        src_gf;
    logic [RW*NSRC-1:0]     src_num;
    logic [WIDTH*NSRC-1:0]  src_data;
    logic                   rsv_valid;
    logic                   rsv_gf;
    logic [RW-1:0]          rsv_num;
    logic [WIDTH*2*NUM-1:0] regs;
    logic [2*NUM-1:0]       busy;
    logic [2*NUM-1:0]       wr_en;

    int errors = 0;
    int checks = 0;

    reg_wb_unit #(.WIDTH(WIDTH), .NUM(NUM), .NSRC(NSRC)) dut (
        .clk       (clk),
        .rst       (rst),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_gf    (src_gf),
        .src_num   (src_num),
        .src_data  (src_data),
        .rsv_valid (rsv_valid),
        .rsv_gf    (rsv_gf),
        .rsv_num   (rsv_num),
        .regs      (regs),
        .busy      (busy),
        .wr_en     (wr_en)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] get_reg(input logic gf, input int num);
        return regs[((gf ? NUM : 0) + num)*WIDTH +: WIDTH];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input int i, input logic v, input logic gf, input int num,
                           input logic [WIDTH-1:0] data);
        src_valid[i]             = v;
        src_gf[i]                = gf;
        src_num[i*RW +: RW]      = RW'(num);
        src_data[i*WIDTH +: WIDTH] = data;
    endtask

    // Drive on the falling edge, sample 1 time unit later for combinational outputs.
    task automatic drive_point();
        @(negedge clk);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    logic [NSRC-1:0] exp_seq [6];
    logic [63:0]     one = 64'd1;

    initial begin
        rst = 1'b1; src_valid = '0; src_gf = '0; src_num = '0; src_data = '0;
        rsv_valid = 1'b0; rsv_gf = 1'b0; rsv_num = '0;
        src_valid = 3'b111;
        #1;
        chk("rst_ready", 64'(src_ready), 64'd0);
        chk("rst_busy", busy, 64'd0);
        chk("rst_wr_en", wr_en, 64'd0);
        chk("rst_regs", 64'(regs == '0), 64'd1);

        drive_point();
        rst = 1'b0; src_valid = '0;

        // Single write: src0 -> general r5
        drive_point();
        set_src(0, 1'b1, 1'b0, 5, 32'hDEADBEEF);
        #1 chk("single_ready", 64'(src_ready), 64'b001);
        after_edge();
        chk("single_r5", 64'(get_reg(1'b0, 5)), 64'hDEADBEEF);
        chk("single_wr_en", wr_en, one << 5);
        drive_point();
        src_valid = '0;
        after_edge();
        chk("idle_wr_en", wr_en, 64'd0);

        // Fairness: pointer is now 1, so grants run 1,2,0,1,2,0
        exp_seq[0] = 3'b010; exp_seq[1] = 3'b100; exp_seq[2] = 3'b001;
        exp_seq[3] = 3'b010; exp_seq[4] = 3'b100; exp_seq[5] = 3'b001;
        drive_point();
        set_src(0, 1'b1, 1'b0, 1, 32'hA0);
        set_src(1, 1'b1, 1'b0, 2, 32'hA1);
        set_src(2, 1'b1, 1'b0, 3, 32'hA2);
        for (int c = 0; c < 6; c++) begin
            #1 chk($sformatf("rr_grant%0d", c), 64'(src_ready), 64'(exp_seq[c]));
            drive_point();
        end
        src_valid = '0;
        #1;
        chk("rr_r1", 64'(get_reg(1'b0, 1)), 64'hA0);
        chk("rr_r2", 64'(get_reg(1'b0, 2)), 64'hA1);
        chk("rr_r3", 64'(get_reg(1'b0, 3)), 64'hA2);

        // Hardwired general r0, ordinary float r0
        drive_point();
        set_src(1, 1'b1, 1'b0, 0, 32'h1234);
        #1 chk("r0_ready", 64'(src_ready), 64'b010);
        after_edge();
        chk("r0_wr_en", wr_en, 64'd0);
        chk("r0_value", 64'(get_reg(1'b0, 0)), 64'd0);
        drive_point();
        set_src(1, 1'b1, 1'b1, 0, 32'h1234);
        #1 chk("f0_ready", 64'(src_ready), 64'b010);
        after_edge();
        chk("f0_value", 64'(get_reg(1'b1, 0)), 64'h1234);
        chk("f0_wr_en", wr_en, one << NUM);
        drive_point();
        src_valid = '0;

        // Scoreboard: reserve float r3, then retire it
        rsv_valid = 1'b1; rsv_gf = 1'b1; rsv_num = 5'd3;
        after_edge();
        chk("rsv_f3", busy, one << (NUM + 3));
        drive_point();
        rsv_valid = 1'b0;
        set_src(0, 1'b1, 1'b1, 3, 32'h55);
        after_edge();
        chk("clr_f3", busy, 64'd0);
        chk("f3_value", 64'(get_reg(1'b1, 3)), 64'h55);

        // Reserve and commit general r7 on the same edge
        drive_point();
        set_src(0, 1'b1, 1'b0, 7, 32'h77);
        rsv_valid = 1'b1; rsv_gf = 1'b0; rsv_num = 5'd7;
        after_edge();
        chk("same_edge_busy", busy, one << 7);
        chk("same_edge_r7", 64'(get_reg(1'b0, 7)), 64'h77);
        drive_point();
        src_valid = '0;
        rsv_gf = 1'b0; rsv_num = 5'd0;
        after_edge();
        chk("rsv_r0_ignored", busy, one << 7);
        drive_point();
        rsv_valid = 1'b0;

        // Pointer is 1: one src1 commit moves it to 2
        set_src(1, 1'b1, 1'b0, 10, 32'h99);
        after_edge();
        drive_point();
        src_valid = '0;
        set_src(0, 1'b1, 1'b0, 9, 32'h11);
        set_src(2, 1'b1, 1'b0, 9, 32'h22);
        #1 chk("coll_first", 64'(src_ready), 64'b100);
        after_edge();
        chk("coll_r9_a", 64'(get_reg(1'b0, 9)), 64'h22);
        drive_point();
        src_valid[2] = 1'b0;
        #1 chk("coll_second", 64'(src_ready), 64'b001);
        after_edge();
        chk("coll_r9_b", 64'(get_reg(1'b0, 9)), 64'h11);
        chk("coll_wr_en", wr_en, one << 9);

        // Reset mid-run with loaded registers
        drive_point();
        src_valid = 3'b111;
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 64'(src_ready), 64'd0);
        chk("mid_rst_busy", busy, 64'd0);
        chk("mid_rst_wr_en", wr_en, 64'd0);
        chk("mid_rst_regs", 64'(regs == '0), 64'd1);
        drive_point();
        rst = 1'b0;
        #1 chk("post_rst_ptr", 64'(src_ready), 64'b001);
        drive_point();
        src_valid = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_wb_unit.md
Name: reg_wb_unit

Overview:
- Parametrised successor to the register write decoder.
- Owns both register banks (general and float) as storage.
- Arbitrates write-back requests from NSRC producers (ALU, FPU, load unit, …) onto one commit per cycle with round-robin fairness.
- Keeps a per-register busy scoreboard that the issue stage sets and write-back clears. Sits between the execute units and the decode/issue stage.

Parameters:
- WIDTH, 32, data width of one register.
- NUM, 32, registers per bank. Must be a power of two, ≥ 2.
- NSRC, 3, number of write-back producers. Range 1..8.
- RW (localparam), $clog2(NUM), register index width.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- src_valid  in  NSRC  per-producer write request.
- src_ready  out  NSRC  per-producer grant; the commit occurs on an edge where valid & ready.
- src_gf  in  NSRC  bank select per producer: 0 general, 1 float.
- src_num  in  RW*NSRC  destination index per producer; slice i is [i*RW +: RW].
- src_data  in  WIDTH*NSRC  write data per producer; slice i is [i*WIDTH +: WIDTH].
- rsv_valid  in  1  issue stage reserves a destination.
- rsv_gf  in  1  bank of the reservation.
- rsv_num  in  RW  index of the reservation.
- regs  out  WIDTH*2*NUM  flattened register contents.
  - General register k is at [k*WIDTH +: WIDTH].
  - Float register k is at [(NUM+k)*WIDTH +: WIDTH].
- busy  out  2*NUM  scoreboard; bit {gf,num} = pending write.
- wr_en  out  2*NUM  registered one-hot of the register committed in the previous cycle; all zero if none.

Behaviour:
- Reset (async, rst=1): all regs, busy and wr_en are 0; round-robin pointer is 0. While rst=1, src_ready is 0.
- Arbitration:
  - Combinational. At most one src_ready bit is high.
  - The grant goes to the first valid source at or after the pointer, scanning upward with wrap.
  - src_ready depends on src_valid. Producers must not make valid depend on ready, and must hold gf/num/data stable until accepted.
- Pointer update: after a grant to source i, the pointer becomes (i+1) mod NSRC. With no grant, the pointer is unchanged.
- Commit, on the edge where source i is granted:
  - regs[{gf,num}] <= data.
  - busy[{gf,num}] <= 0.
  - wr_en <= one-hot({gf,num}).
  - The new value is visible on regs from the following cycle; there is no internal bypass.
- General register 0 is hardwired zero:
  - A commit to gf=0, num=0 is accepted (handshake completes, pointer advances) but storage is unchanged.
  - That commit sets wr_en to all zero and leaves busy unchanged.
- No grant in a cycle: wr_en <= 0 and regs are unchanged.
- Reservation: rsv_valid=1 sets busy[{rsv_gf,rsv_num}] on the edge. A reservation of general r0 is ignored.
- Reservation and commit to the same register on the same edge: the set wins (busy=1). The reservation is newer than the write being retired.
- Reservation of a register that is already busy: busy stays 1. There is no counting; the issue stage stalls on busy before reserving.
- Two producers targeting the same register: serialised by the arbiter. The last granted commit determines the final value.
- Float bank index 0 is an ordinary register.
- Latency: 0 cycles request→grant; 1 cycle grant→regs/wr_en visible.
- Reset asserted mid-transfer: the pending request is dropped and all state clears immediately. Producers re-present after rst deasserts.

Decomposition:
- Shared package holds:
  - Defaults WIDTH=32, NUM=32.
  - Bank encoding constants BANK_GENERAL=0, BANK_FLOAT=1.
  - A function flat_idx(gf, num) returning {gf,num}, used by this block and the issue stage.
- One natural sub-module: rr_arbiter.
  - Parameter N.
  - Inputs: req[N], clk, rst.
  - Outputs: one-hot gnt[N] and the held pointer.
  - Instantiated with N=NSRC.
- Register storage and scoreboard stay in reg_wb_unit.

Test Plan:
1. Reset check: rst pulse mid-run with regs loaded → regs, busy and wr_en read 0 in the same cycle; src_ready=0 while rst=1.
2. Single write: src0 writes gf=0, num=5, data=0xDEADBEEF → src_ready[0]=1 that cycle; next cycle regs general r5=0xDEADBEEF and wr_en has only bit 5 set.
3. Fairness, NSRC=3: all three valid continuously with distinct destinations → grants in order 0,1,2,0,1,2; pointer wraps correctly.
4. Hardwired zero: src1 writes gf=0, num=0, data=0x1234 → handshake completes, wr_en=0, general r0 stays 0. The same write with gf=1 → float r0=0x1234 and wr_en bit NUM set.
5. Scoreboard: rsv float r3 → busy bit NUM+3=1; a later commit to float r3 clears it. A rsv and a commit to general r7 on the same edge → busy bit 7 stays 1 and regs r7 takes the committed data.
6. Same-destination collision: src0 (data=0x11) and src2 (data=0x22) both target general r9 with the pointer at 2 → src2 commits first, then src0; final r9=0x11.
